// File: rtl/instr_fetch.sv
// Instruction fetch stage for the multicycle MIPS core.
// Owns the PC, performs one Avalon-MM read per fetch request, optionally byte-swaps the returned
// word, and presents it to the IR with a one-cycle valid strobe. Branch/jump targets take effect
// after the delay slot; execution stops (active_o low) once the PC reaches HALT_ADDR.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000,
  parameter bit          BYTE_SWAP    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_ni,
  // Controller interface
  input  logic        fetch_i,
  input  logic        advance_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] pc_o,
  // Avalon-MM read master
  output logic [31:0] address_o,
  output logic        read_o,
  input  logic        waitrequest_i,
  input  logic [31:0] readdata_i,
  // Instruction register interface
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  // Status
  output logic        active_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StValid
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        active_q, active_d;
  logic        fault_q, fault_d;
  logic        delay_pending_q, delay_pending_d;
  logic [31:0] delay_target_q, delay_target_d;

  logic        in_idle;
  logic        fetch_req;
  logic        pc_aligned;
  logic        advance_go;
  logic        fetch_go;
  logic        fault_set;
  logic        capture;
  logic [31:0] pc_next_seq;
  logic [31:0] rd_swapped;

  // Decode controller requests; advance takes priority over fetch in the same cycle.
  always_comb begin
    in_idle    = (state_q == StIdle);
    pc_aligned = (pc_q[1:0] == 2'b00);
    advance_go = in_idle && advance_i && active_q;
    // A fetch is only considered when no advance competes and execution is live and fault-free.
    fetch_req  = in_idle && fetch_i && !advance_i && active_q && !fault_q;
    fetch_go   = fetch_req && pc_aligned;
    fault_set  = fetch_req && !pc_aligned;
    capture    = (state_q == StReq) && !waitrequest_i;
  end

  // Byte-order adaptation of the bus word.
  always_comb begin
    if (BYTE_SWAP) begin
      rd_swapped = {readdata_i[7:0], readdata_i[15:8], readdata_i[23:16], readdata_i[31:24]};
    end else begin
      rd_swapped = readdata_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: one read per fetch, then a single valid cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_go) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (!waitrequest_i) begin
          state_d = StValid;
        end
      end
      StValid: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM outputs: read held for the whole request phase, strobe for the one valid cycle.
  always_comb begin
    read_o        = (state_q == StReq);
    instr_valid_o = (state_q == StValid);
  end

  // Next PC / delay-slot bookkeeping.
  always_comb begin
    pc_next_seq     = pc_q + 32'd4;
    pc_d            = pc_q;
    delay_pending_d = delay_pending_q;
    delay_target_d  = delay_target_q;
    active_d        = active_q;
    if (advance_go) begin
      // A pending target consumes this advance; otherwise step sequentially (wraps at 2^32).
      if (delay_pending_q) begin
        pc_d = delay_target_q;
      end else begin
        pc_d = pc_next_seq;
      end
      // A jump retiring in a delay slot still arms its own target for the next advance.
      if (jump_i) begin
        delay_pending_d = 1'b1;
        delay_target_d  = jump_target_i;
      end else begin
        delay_pending_d = 1'b0;
      end
      if (pc_d == HALT_ADDR) begin
        active_d = 1'b0;
      end
    end
  end

  // Instruction capture and sticky fault.
  always_comb begin
    instr_d = instr_q;
    fault_d = fault_q;
    if (capture) begin
      instr_d = rd_swapped;
    end
    if (fault_set) begin
      fault_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q            <= RESET_VECTOR;
      instr_q         <= 32'h0;
      active_q        <= 1'b1;
      fault_q         <= 1'b0;
      delay_pending_q <= 1'b0;
      delay_target_q  <= 32'h0;
    end else begin
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      active_q        <= active_d;
      fault_q         <= fault_d;
      delay_pending_q <= delay_pending_d;
      delay_target_q  <= delay_target_d;
    end
  end

  // Registered values driven straight out; the bus address always tracks the PC.
  always_comb begin
    pc_o      = pc_q;
    address_o = pc_q;
    instr_o   = instr_q;
    active_o  = active_q;
    fault_o   = fault_q;
  end

endmodule
